// File: rtl/rr_grant_arbiter_pkg.sv
// Shared definitions for the 4-requester round-robin arbiter: sizes,
// FSM state type and the rotating priority search.
package rr_grant_arbiter_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // First set bit of mask visiting ptr+1, ptr+2, ptr+3, ptr (mod N_REQ).
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] mask,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] win;
    logic             found;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!found && mask[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_grant_arbiter_onehot_dec.sv
// 2-to-4 decoder with enable; turns the registered owner index and valid
// flag into the one-hot grant vector.
module rr_onehot_dec
  import rr_grant_arbiter_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter for 4 agents with direct handoff on release.
// Optional hold-timeout preemption enabled by defining RR_ARB_TIMEOUT_EN.
module rr_grant_arbiter
  import rr_grant_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             preempt
);

  if (MAX_HOLD < 2 || (2 ** HOLD_W) <= MAX_HOLD) begin : g_param_check
    $error("rr_grant_arbiter: need MAX_HOLD >= 2 and 2**HOLD_W > MAX_HOLD");
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             preempt_q, preempt_d;
`ifdef RR_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0]  others;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= IDX_W'(N_REQ - 1);
      idx_q     <= '0;
      valid_q   <= 1'b0;
      preempt_q <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      preempt_q <= preempt_d;
`ifdef RR_ARB_TIMEOUT_EN
      hold_q    <= hold_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    preempt_d = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    others    = req;
    others[idx_q] = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_GRANT;
          idx_d   = rr_pick(req, ptr_q);
          valid_d = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (!req[idx_q]) begin
          // Owner's bit is already clear, so searching req from the old
          // owner hands off directly without an idle cycle.
          ptr_d = idx_q;
`ifdef RR_ARB_TIMEOUT_EN
          hold_d = '0;
`endif
          if (|req) begin
            idx_d = rr_pick(req, idx_q);
          end else begin
            state_d = ST_IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
          end
        end
`ifdef RR_ARB_TIMEOUT_EN
        else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
          hold_d = '0;
          if (|others) begin
            ptr_d     = idx_q;
            idx_d     = rr_pick(others, idx_q);
            preempt_d = 1'b1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
    endcase
  end

  rr_onehot_dec u_dec (
    .idx    (idx_q),
    .en     (valid_q),
    .onehot (grant)
  );

  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  assign preempt     = preempt_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter: driver pushes model predictions,
// monitor pops and compares one entry per clock.
module tb_rr_grant_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int HOLD_W   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       preempt;

  typedef struct {
    logic [3:0] g;
    logic [1:0] idx;
    logic       v;
    logic       p;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: owner (-1 when idle), rotation pointer, cycles held.
  int m_owner = -1;
  int m_ptr   = 3;
  int m_hold  = 0;
  bit m_pre   = 0;

  always #5 clk = ~clk;

  rr_grant_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .preempt     (preempt)
  );

  function automatic int pick(input logic [3:0] mask, input int from);
    for (int k = 1; k <= 4; k++) begin
      if (mask[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] rq);
    logic [3:0] oth;
    m_pre = 0;
    if (r) begin
      m_owner = -1; m_ptr = 3; m_hold = 0;
    end else if (m_owner < 0) begin
      m_owner = pick(rq, m_ptr);
      m_hold  = 0;
    end else if (!rq[m_owner]) begin
      m_ptr   = m_owner;
      m_owner = pick(rq, m_ptr);
      m_hold  = 0;
    end else begin
`ifdef RR_ARB_TIMEOUT_EN
      if (m_hold + 1 >= MAX_HOLD) begin
        oth = rq;
        oth[m_owner] = 1'b0;
        m_hold = 0;
        if (oth != 4'b0) begin
          m_ptr   = m_owner;
          m_owner = pick(oth, m_owner);
          m_pre   = 1;
        end
      end else begin
        m_hold++;
      end
`else
      oth = rq;
`endif
    end
  endtask

  task automatic cyc(input logic r, input logic [3:0] rq);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    model_step(r, rq);
    e.v   = (m_owner >= 0);
    e.idx = e.v ? 2'(m_owner) : 2'd0;
    e.g   = e.v ? (4'b0001 << m_owner) : 4'b0000;
    e.p   = m_pre;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (grant !== e.g || grant_idx !== e.idx || grant_valid !== e.v || preempt !== e.p) begin
          failures++;
          $display("FAIL outputs t=%0t got grant=%b idx=%0d valid=%b preempt=%b exp grant=%b idx=%0d valid=%b preempt=%b",
                   $time, grant, grant_idx, grant_valid, preempt, e.g, e.idx, e.v, e.p);
        end
        checks++;
        if (grant !== (grant_valid ? (4'b0001 << grant_idx) : 4'b0000)) begin
          failures++;
          $display("FAIL onehot t=%0t got grant=%b with idx=%0d valid=%b", $time, grant, grant_idx, grant_valid);
        end
      end
    end
  end

  initial begin : driver
    logic [3:0] rq;
    int         len;
    rst = 1'b1;
    req = 4'b0000;

    // Reset with everyone requesting, then first grant goes to agent 0.
    cyc(1'b1, 4'hF);
    cyc(1'b1, 4'hF);
    cyc(1'b0, 4'hF);
    cyc(1'b1, 4'h0);

    // Single requester holding then releasing.
    for (int i = 0; i < 11; i++) cyc(1'b0, 4'b0100);
    cyc(1'b0, 4'b0000);
    cyc(1'b0, 4'b0000);

    // All requesting; owner drops for one cycle after each grant.
    cyc(1'b1, 4'h0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 4'hF);
      rq = 4'hF;
      if (m_owner >= 0) rq[m_owner] = 1'b0;
      cyc(1'b0, rq);
    end

    // Release and new request in the same cycle.
    cyc(1'b1, 4'h0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0001);
    cyc(1'b0, 4'b1000);
    cyc(1'b0, 4'b1000);
    cyc(1'b0, 4'b0000);

    // Two constant requesters: preemption only with the timeout feature.
    cyc(1'b1, 4'h0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 4'b0101);

    // Reset mid-grant of agent 1, then search restarts at agent 0.
    cyc(1'b1, 4'h0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0010);
    cyc(1'b1, 4'b0010);
    cyc(1'b0, 4'hF);
    cyc(1'b0, 4'h0);

    // Randomised traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      rq  = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 12);
      for (int j = 0; j < len; j++) begin
        if (j > 0 && $urandom_range(0, 3) == 0) rq = rq ^ (4'b0001 << $urandom_range(0, 3));
        cyc(($urandom_range(0, 60) == 0) ? 1'b1 : 1'b0, rq);
      end
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending entries exp 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
